// File: rtl/regfile_sb.sv
// Register file with write-through read bypass, a PC alias at the top index,
// and a scoreboard of pending writebacks that produces per-port RAW hazard flags.
module regfile_sb #(
    parameter int DW    = 32,
    parameter int NREGS = 16,
    localparam int AW   = $clog2(NREGS),
    localparam int CW   = $clog2(NREGS) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we3,
    input  logic [AW-1:0]     wa3,
    input  logic [DW-1:0]     wd3,
    input  logic [DW-1:0]     r15,
    input  logic [AW-1:0]     ra1,
    input  logic [AW-1:0]     ra2,
    output logic [DW-1:0]     rd1,
    output logic [DW-1:0]     rd2,
    input  logic              iss_valid,
    input  logic [AW-1:0]     iss_rd,
    output logic              haz1,
    output logic              haz2,
    output logic [NREGS-1:0]  busy,
    output logic [CW-1:0]     pend_cnt
);

    localparam logic [AW-1:0] PC_IDX = AW'(NREGS - 1);

    logic [DW-1:0]    regs_q [NREGS-1];
    logic [DW-1:0]    regs_d [NREGS-1];
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic [CW-1:0]    pend_cnt_q;
    logic [CW-1:0]    pend_cnt_d;

    logic wr_en;
    logic iss_en;

    // The PC index has no backing storage, so writes and issues to it are dropped.
    assign wr_en  = we3 && (wa3 != PC_IDX);
    assign iss_en = iss_valid && (iss_rd != PC_IDX);

    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[wa3] = wd3;
        end
    end

    // Clear before set: a same-cycle issue marks the new producer as pending.
    always_comb begin
        busy_d = busy_q;
        if (wr_en) begin
            busy_d[wa3] = 1'b0;
        end
        if (iss_en) begin
            busy_d[iss_rd] = 1'b1;
        end
        busy_d[NREGS-1] = 1'b0;
    end

    always_comb begin
        pend_cnt_d = '0;
        for (int i = 0; i < NREGS; i++) begin
            pend_cnt_d = pend_cnt_d + CW'(busy_d[i]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regs_q     <= '{default: '0};
            busy_q     <= '0;
            pend_cnt_q <= '0;
        end else begin
            regs_q     <= regs_d;
            busy_q     <= busy_d;
            pend_cnt_q <= pend_cnt_d;
        end
    end

    assign rd1 = (ra1 == PC_IDX)            ? r15 :
                 (we3 && (wa3 == ra1))      ? wd3 :
                                              regs_q[ra1];
    assign rd2 = (ra2 == PC_IDX)            ? r15 :
                 (we3 && (wa3 == ra2))      ? wd3 :
                                              regs_q[ra2];

    // A writeback landing this cycle resolves the hazard it would otherwise report.
    assign haz1 = busy_q[ra1] && !(we3 && (wa3 == ra1));
    assign haz2 = busy_q[ra2] && !(we3 && (wa3 == ra2));

    assign busy     = busy_q;
    assign pend_cnt = pend_cnt_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: reset, write/bypass, PC alias, scoreboard
// lifecycle, issue/writeback collision and asynchronous reset.
module tb_regfile_sb;

    localparam int DW    = 32;
    localparam int NREGS = 16;
    localparam int AW    = $clog2(NREGS);
    localparam int CW    = $clog2(NREGS) + 1;

    logic              clk;
    logic              reset;
    logic              we3;
    logic [AW-1:0]     wa3;
    logic [DW-1:0]     wd3;
    logic [DW-1:0]     r15;
    logic [AW-1:0]     ra1;
    logic [AW-1:0]     ra2;
    logic [DW-1:0]     rd1;
    logic [DW-1:0]     rd2;
    logic              iss_valid;
    logic [AW-1:0]     iss_rd;
    logic              haz1;
    logic              haz2;
    logic [NREGS-1:0]  busy;
    logic [CW-1:0]     pend_cnt;

    int checks = 0;
    int errors = 0;

    regfile_sb #(.DW(DW), .NREGS(NREGS)) dut (
        .clk       (clk),
        .reset     (reset),
        .we3       (we3),
        .wa3       (wa3),
        .wd3       (wd3),
        .r15       (r15),
        .ra1       (ra1),
        .ra2       (ra2),
        .rd1       (rd1),
        .rd2       (rd2),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .haz1      (haz1),
        .haz2      (haz2),
        .busy      (busy),
        .pend_cnt  (pend_cnt)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // checker
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // drivers: step lands 1ns after a rising edge; settle lets combinational paths update
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle();
        we3       = 1'b0;
        wa3       = '0;
        wd3       = '0;
        iss_valid = 1'b0;
        iss_rd    = '0;
    endtask

    task automatic issue(input logic [AW-1:0] rd);
        iss_valid = 1'b1;
        iss_rd    = rd;
    endtask

    task automatic write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        we3 = 1'b1;
        wa3 = a;
        wd3 = d;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        r15 = '0;
        ra1 = '0;
        ra2 = '0;

        // writes and issues while in reset must be discarded
        write(4'd4, 32'h1234_5678);
        issue(4'd4);
        step();
        step();
        reset = 1'b0;
        idle();
        ra1 = 4'd4;
        settle();
        check("rst_discard_rd", rd1, 0);
        check("rst_discard_busy", busy, 0);

        // reset state
        ra1 = 4'd3;
        ra2 = 4'd0;
        settle();
        check("rst_rd1", rd1, 0);
        check("rst_rd2", rd2, 0);
        check("rst_haz1", haz1, 0);
        check("rst_haz2", haz2, 0);
        check("rst_pend", pend_cnt, 0);

        // write with same-cycle bypass
        write(4'd5, 32'hDEAD_BEEF);
        ra1 = 4'd5;
        ra2 = 4'd5;
        settle();
        check("bypass_rd1", rd1, 32'hDEAD_BEEF);
        check("bypass_same_addr", rd2, 32'hDEAD_BEEF);
        step();
        idle();
        settle();
        check("stored_rd1", rd1, 32'hDEAD_BEEF);
        check("stored_rd2", rd2, 32'hDEAD_BEEF);

        // PC alias: reads return r15, writes and issues to it are ignored
        r15 = 32'h100;
        ra1 = 4'd5;
        ra2 = 4'd15;
        write(4'd15, 32'h55);
        issue(4'd15);
        settle();
        check("pc_rd2", rd2, 32'h100);
        check("pc_haz2", haz2, 0);
        step();
        idle();
        settle();
        check("pc_busy", busy, 0);
        check("pc_pend", pend_cnt, 0);
        check("pc_storage_r5", rd1, 32'hDEAD_BEEF);
        check("pc_rd2_after", rd2, 32'h100);

        // hazard lifecycle on r2
        issue(4'd2);
        step();
        idle();
        ra1 = 4'd2;
        ra2 = 4'd2;
        settle();
        check("haz_busy_set", busy, 16'h0004);
        check("haz_pend_1", pend_cnt, 1);
        check("haz1_set", haz1, 1);
        check("haz2_same_addr", haz2, 1);
        write(4'd2, 32'hA5A5_0001);
        settle();
        check("haz1_resolved", haz1, 0);
        check("haz_wb_rd1", rd1, 32'hA5A5_0001);
        step();
        idle();
        settle();
        check("haz_busy_clr", busy, 0);
        check("haz_pend_0", pend_cnt, 0);
        check("haz_rd1_stored", rd1, 32'hA5A5_0001);

        // issue/writeback collision on r7: issue wins
        issue(4'd7);
        step();
        idle();
        settle();
        check("col_busy_pre", busy, 16'h0080);
        check("col_pend_pre", pend_cnt, 1);
        issue(4'd7);
        write(4'd7, 32'h77);
        step();
        idle();
        ra1 = 4'd7;
        settle();
        check("col_busy", busy, 16'h0080);
        check("col_pend", pend_cnt, 1);
        check("col_rd1", rd1, 32'h77);
        check("col_haz1", haz1, 1);

        // re-issue to an already-busy register does not double count
        issue(4'd7);
        step();
        idle();
        settle();
        check("reissue_busy", busy, 16'h0080);
        check("reissue_pend", pend_cnt, 1);

        // retire r7 while issuing r1, then r2 and r3
        issue(4'd1);
        write(4'd7, 32'h78);
        step();
        issue(4'd2);
        step();
        issue(4'd3);
        step();
        idle();
        settle();
        check("pre_arst_busy", busy, 16'h000E);
        check("pre_arst_pend", pend_cnt, 3);

        // asynchronous reset pulse between edges
        ra1 = 4'd5;
        reset = 1'b1;
        settle();
        check("arst_busy", busy, 0);
        check("arst_pend", pend_cnt, 0);
        check("arst_storage", rd1, 0);
        reset = 1'b0;

        // first edge after reset performs normal updates
        write(4'd6, 32'h66);
        issue(4'd9);
        step();
        idle();
        ra1 = 4'd6;
        ra2 = 4'd9;
        settle();
        check("post_rst_rd1", rd1, 32'h66);
        check("post_rst_busy", busy, 16'h0200);
        check("post_rst_pend", pend_cnt, 1);
        check("post_rst_haz2", haz2, 1);

        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
